serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
//
// PURPOSE
//   Bit-serial multi-bit adder built around a one-bit full-adder cell.
//   Operand shift registers feed the cell LSB-first, one bit per clock.
//   A carry flip-flop closes the loop from cout back to cin.
//   Sum bits are shifted into a result register; a start/busy/done handshake frames each add.
//
// PARAMETERS
//   WIDTH   8   operand and sum width in bits (WIDTH >= 2)
//
// PORTS
//   clk     in   1      rising-edge clock, single clock domain
//   reset   in   1      synchronous, active-high reset
//   start   in   1      request an add; sampled only in IDLE
//   a_in    in   WIDTH  operand A; captured on the accepted start edge
//   b_in    in   WIDTH  operand B; captured on the accepted start edge
//   cin_in  in   1      carry-in to bit 0; captured on the accepted start edge
//   busy    out  1      high while in RUN
//   done    out  1      one-cycle pulse; sum/cout valid
//   sum     out  WIDTH  registered result; holds until the next accepted start
//   cout    out  1      registered carry-out of bit WIDTH-1; holds with sum
//
// BEHAVIOUR
//   Reset: sync, active-high. All flops clear on the next clk edge; reset wins over all other inputs.
//     state=IDLE; busy, done, sum, cout, carry, count and all shift registers = 0.
//   FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE
//     - start=1 at edge k: a_sh<=a_in, b_sh<=b_in, carry<=cin_in, count<=0, sum_sh<=0; go RUN.
//     - start=0: stay in IDLE; sum and cout hold their values.
//   RUN (edges k+1 .. k+WIDTH)
//     - Full-adder cell: s = a_sh[0]^b_sh[0]^carry; c = maj(a_sh[0], b_sh[0], carry).
//     - sum_sh <= {s, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; carry <= c.
//     - count increments by 1 per edge.
//     - At the edge where count == WIDTH-1: sum <= {s, sum_sh[WIDTH-1:1]}, cout <= c; go DONE.
//   DONE: done=1 for exactly one cycle, from edge k+WIDTH to edge k+WIDTH+1; then go IDLE.
//   Timing
//     - busy = (state==RUN). done = (state==DONE). Both decode directly from state flops.
//     - Latency: start sampled at edge k -> done high in cycle [k+WIDTH, k+WIDTH+1).
//     - Minimum start-to-start spacing is WIDTH+2 edges.
//   Start handling
//     - start is ignored in RUN and DONE; the request is not queued.
//     - The upstream block holds or re-issues start until busy is observed.
//   Input capture
//     - a_in, b_in and cin_in changes after capture have no effect on the add in progress.
//   Arithmetic
//     - Result is {cout,sum} = a_in + b_in + cin_in, modulo 2^(WIDTH+1); no overflow flag.
//   Count width: $clog2(WIDTH) bits; never wraps in normal use.
//   Reset in RUN or DONE
//     - Aborts the add and returns to IDLE; sum and cout clear to 0.
//     - No done pulse is issued.
//   Reset and start on the same edge: reset wins; start is dropped.
//
// TESTING (WIDTH=8 unless noted)
//   1. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. done exactly 8 edges after start edge; busy high 8 cycles.
//   2. a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
//   3. Start a=0x12, b=0x34, cin=0; pulse start with a=0xFF, b=0xFF during RUN; change a_in, b_in mid-run
//      -> sum=0x46, cout=0, one done pulse only.
//   4. Start a=0x7F, b=0x7F; assert reset at the 4th RUN edge -> next cycle busy=0, done=0, sum=0, cout=0.
//      Restart a=0x03, b=0x04 -> sum=0x07.
//   5. Hold start=1 continuously for 40 cycles -> add restarts every 10 edges (WIDTH+2); done pulses are one cycle wide.
//   6. WIDTH=2: exhaustive over all 32 combinations of a, b, cin -> {cout,sum} == a+b+cin every time.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell, fed LSB-first from operand shift
// registers, with a carry flop closing cout back to cin. A start/busy/done
// handshake frames each WIDTH-cycle add; sum/cout are registered and held.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IDLE | waiting for start; sum/cout hold the last result
//   S_RUN  | one bit per clock through the full-adder cell (busy=1)
//   S_DONE | one-cycle done pulse; sum/cout valid
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    count_q, count_d;

    logic fa_s;
    logic fa_c;

    // Full-adder cell on the current LSBs and the looped-back carry.
    always_comb begin
        fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    end

    // Next-state and datapath update; everything holds unless the state says otherwise.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d   = a_in;
                    b_sh_d   = b_in;
                    carry_d  = cin_in;
                    count_d  = '0;
                    sum_sh_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d  = fa_c;
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
                    // Last bit: publish the result and park the counter.
                    sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    count_d = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            count_q  <= count_d;
        end
    end

    // Handshake outputs decode straight from the state flops.
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 instance checked every cycle against a
// timing/arithmetic model, plus a WIDTH=2 instance swept exhaustively.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic         start2;
    logic [1:0]   a2;
    logic [1:0]   b2;
    logic         cin2;
    logic         busy2;
    logic         done2;
    logic [1:0]   sum2;
    logic         cout2;

    int checks = 0;
    int passed = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a_in(a), .b_in(b), .cin_in(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .a_in(a2), .b_in(b2), .cin_in(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Model: edges elapsed since the accepted start (-1 = idle). busy for
    // edges 0..W-1 after it, done at W, result = a+b+cin published at W.
    int       since = -1;
    logic [W:0] pend = '0;
    logic [W:0] exp_res = '0;
    logic     model_on = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            since    <= -1;
            exp_res  <= '0;
            model_on <= 1'b1;
        end else if (model_on) begin
            if (since == -1) begin
                if (start) begin
                    since <= 0;
                    pend  <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                end
            end else if (since == W) begin
                since <= -1;
            end else begin
                since <= since + 1;
                if (since == W - 1) exp_res <= pend;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("model_busy", {31'b0, busy}, {31'b0, (since >= 0 && since < W)});
            chk("model_done", {31'b0, done}, {31'b0, (since == W)});
            if (since == -1 || since == W) begin
                chk("model_sum",  {24'b0, sum}, {23'b0, exp_res[W-1:0]});
                chk("model_cout", {31'b0, cout}, {31'b0, exp_res[W]});
            end
        end
    end

    // One add on the WIDTH=8 instance with latency/busy-length and literal result checks.
    task automatic do_add(input string nm, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic [7:0] es, input logic ec);
        int n = 0;
        int busy_n = 0;
        bit got = 0;
        a = av; b = bv; cin = cv; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (n < 30 && !got) begin
            @(negedge clk);
            if (done) got = 1;
            else begin
                if (busy) busy_n++;
                n++;
            end
        end
        chk({nm, "_done_seen"}, {31'b0, got}, 32'd1);
        chk({nm, "_latency"}, n, 8);
        chk({nm, "_busy_cycles"}, busy_n, 8);
        chk({nm, "_sum"}, {24'b0, sum}, {24'b0, es});
        chk({nm, "_cout"}, {31'b0, cout}, {31'b0, ec});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int dn;
        int first_done;
        int last_done;
        bit spacing_ok;
        bit prev_done;
        bit wide_pulse;

        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_sum", {24'b0, sum}, 32'd0);
        chk("reset_cout", {31'b0, cout}, 32'd0);
        @(posedge clk); #1;

        // Tests 1 and 2
        do_add("t1_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        do_add("t2_a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        do_add("t2_00_00", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        do_add("misc_c3_6e", 8'hC3, 8'h6E, 1'b0, 8'h31, 1'b1);

        // Test 3: start and operand changes during RUN are ignored
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 a = 8'h5C; b = 8'hE1;
        dn = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                chk("t3_sum", {24'b0, sum}, 32'h46);
                chk("t3_cout", {31'b0, cout}, 32'd0);
            end
        end
        chk("t3_done_pulses", dn, 1);
        @(posedge clk); #1;

        // Test 4: reset at the 4th RUN edge aborts and clears
        a = 8'h7F; b = 8'h7F; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; start = 1'b1;
        @(posedge clk); #1 reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("t4_busy", {31'b0, busy}, 32'd0);
        chk("t4_done", {31'b0, done}, 32'd0);
        chk("t4_sum", {24'b0, sum}, 32'd0);
        chk("t4_cout", {31'b0, cout}, 32'd0);
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("t4_no_done_after_abort", dn, 0);
        @(posedge clk); #1;
        do_add("t4_restart", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

        // Test 5: start held high for 40 cycles restarts every W+2 edges
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        dn = 0; first_done = -1; last_done = -1; spacing_ok = 1; prev_done = 0; wide_pulse = 0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) begin
                if (prev_done) wide_pulse = 1;
                if (first_done < 0) first_done = n;
                else if (n - last_done != 10) spacing_ok = 0;
                last_done = n;
                dn++;
            end
            prev_done = done;
        end
        #1 start = 1'b0;
        chk("t5_done_count", dn, 4);
        chk("t5_first_done", first_done, 8);
        chk("t5_spacing", {31'b0, spacing_ok}, 32'd1);
        chk("t5_pulse_width", {31'b0, wide_pulse}, 32'd0);
        chk("t5_sum", {24'b0, sum}, 32'h30);
        repeat (12) @(posedge clk);
        #1;

        // Test 6: WIDTH=2 exhaustive
        for (int v = 0; v < 32; v++) begin
            int lat;
            bit got;
            logic [2:0] expv;
            a2 = v[1:0]; b2 = v[3:2]; cin2 = v[4];
            expv = {1'b0, a2} + {1'b0, b2} + {2'b0, cin2};
            start2 = 1'b1;
            @(posedge clk); #1 start2 = 1'b0;
            lat = 0; got = 0;
            while (lat < 10 && !got) begin
                @(negedge clk);
                if (done2) got = 1;
                else lat++;
            end
            chk("w2_latency", lat, 2);
            chk("w2_result", {29'b0, cout2, sum2}, {29'b0, expv});
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
